fetch_ctrl: RTL and testbench

Instruction fetch controller that sequences the combinational instruction ROM (`imem`). It keeps a fetch PC and drives the ROM word address every cycle. Each returned word is buffered, with its PC, in a small prefetch FIFO, and that FIFO feeds decode over a valid/ready handshake. Branch and jump redirects from the execute stage flush the buffer and restart fetch at the target.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_ctrl.sv | 107 ++++++++++
 tb/tb_fetch_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_pkg;

    localparam int          FETCH_XLEN     = 32;
    localparam int          FETCH_DEPTH    = 4;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    // One prefetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t with push, pop and flush.
// A flush empties the FIFO and wins over push and pop in the same cycle.
// Entry storage is not reset; only the pointers and count are.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  fetch_entry_t      push_data,
    input  logic              pop,
    input  logic              flush,
    output fetch_entry_t      head,
    output logic [CW-1:0]     count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            pop_eff;
    logic            push_eff;

    // Next pointer and occupancy values; flush clears everything.
    always_comb begin
        pop_eff  = pop && (count_q != '0);
        push_eff = push && ((count_q != DEPTH_C) || pop_eff) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_eff, pop_eff})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write at the tail.
    always_ff @(posedge clk) begin
        if (push_eff) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequential fetch from a combinational ROM
// into a prefetch FIFO, with redirect flush/restart.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (halt on misaligned redirect).
// XLEN must match fetch_pkg::FETCH_XLEN, the width of the entry PC field.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int               XLEN       = 32,
    parameter int               ADDR_WIDTH = 8,
    parameter int               DEPTH      = FETCH_DEPTH,
    parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(FETCH_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-3:0] imem_addr,
    input  logic [31:0]           imem_rd,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [XLEN-1:0]       out_pc,
    output logic                  fetch_misalign
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [XLEN-1:0] ALIGN_M = ~XLEN'(3);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            halted;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = !halted && !redirect_valid && ((count < DEPTH_C) || pop);
    assign imem_addr = fetch_pc_q[ADDR_WIDTH-1:2];

    // Next fetch PC: redirect target (word aligned) beats sequential advance.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) fetch_pc_d = redirect_pc & ALIGN_M;
        else if (push)      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end

    // Fetch PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_pc_q <= RESET_PC;
        else        fetch_pc_q <= fetch_pc_d;
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic halted_q, halted_d;
    logic misalign_q, misalign_d;

    // A misaligned redirect halts fetch until the next aligned redirect.
    always_comb begin
        halted_d   = halted_q;
        misalign_d = misalign_q;
        if (redirect_valid) begin
            halted_d   = (redirect_pc[1:0] != 2'b00);
            misalign_d = (redirect_pc[1:0] != 2'b00);
        end
    end

    // Halt and sticky misalign flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
        end
    end

    assign halted         = halted_q;
    assign fetch_misalign = misalign_q;
`else
    assign halted         = 1'b0;
    assign fetch_misalign = 1'b0;
`endif

    assign push_entry.pc    = fetch_pc_q;
    assign push_entry.instr = imem_rd;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    assign out_instr = out_valid ? head.instr : 32'h0;
    assign out_pc    = out_valid ? head.pc    : '0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl. ROM word n holds the value n.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_misalign;

    int checks;
    int failures;

    fetch_ctrl #(
        .XLEN       (32),
        .ADDR_WIDTH (8),
        .DEPTH      (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_misalign (fetch_misalign)
    );

    assign imem_rd = 32'(imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst_n          = 1'b0;
        out_ready      = rdy;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_instr", out_instr, 32'd0);
        check_eq("rst_pc", out_pc, 32'd0);
        check_eq("rst_misalign", 32'(fetch_misalign), 32'd0);
        check_eq("rst_addr", 32'(imem_addr), 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Streaming from reset with out_ready held high.
        do_reset(1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq("stream_valid", 32'(out_valid), 32'd1);
            check_eq("stream_pc", out_pc, 32'(4 * k));
            check_eq("stream_instr", out_instr, 32'(k));
        end

        // Mid-operation reset, then stall with out_ready low.
        do_reset(1'b0);
        for (int k = 0; k < 10; k++) tick();
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        check_eq("stall_head_pc", out_pc, 32'h0);
        check_eq("stall_head_instr", out_instr, 32'h0);
        check_eq("stall_addr", 32'(imem_addr), 32'd4);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_eq("drain_valid", 32'(out_valid), 32'd1);
            check_eq("drain_pc", out_pc, 32'(4 * k));
            check_eq("drain_instr", out_instr, 32'(k));
            tick();
        end

        // Redirect to 0x40 with three entries buffered.
        do_reset(1'b0);
        for (int k = 0; k < 3; k++) tick();
        check_eq("pre_redir_addr", 32'(imem_addr), 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check_eq("redir_bubble_valid", 32'(out_valid), 32'd0);
        check_eq("redir_bubble_instr", out_instr, 32'd0);
        check_eq("redir_addr", 32'(imem_addr), 32'd16);
        tick();
        check_eq("redir_valid", 32'(out_valid), 32'd1);
        check_eq("redir_pc", out_pc, 32'h40);
        check_eq("redir_instr", out_instr, 32'd16);

        // Fill to full, then redirect and pop in the same cycle.
        for (int k = 0; k < 3; k++) tick();
        check_eq("full_addr", 32'(imem_addr), 32'd20);
        tick();
        check_eq("full_hold_addr", 32'(imem_addr), 32'd20);
        check_eq("full_head_pc", out_pc, 32'h40);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3F8;
        tick();
        redirect_valid = 1'b0;
        check_eq("rp_empty", 32'(out_valid), 32'd0);
        tick();
        check_eq("rp_pc", out_pc, 32'h3F8);
        check_eq("rp_instr", out_instr, 32'd62);
        check_eq("wrap_addr_63", 32'(imem_addr), 32'd63);
        tick();
        check_eq("wrap_pc_3fc", out_pc, 32'h3FC);
        check_eq("wrap_addr_0", 32'(imem_addr), 32'd0);
        tick();
        check_eq("wrap_pc_400", out_pc, 32'h400);
        check_eq("wrap_instr_400", out_instr, 32'd0);
        check_eq("wrap_addr_1", 32'(imem_addr), 32'd1);

        // Misaligned redirect to 0x42.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        redirect_valid = 1'b0;
        check_eq("mis_flush_valid", 32'(out_valid), 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check_eq("mis_flag", 32'(fetch_misalign), 32'd1);
        for (int k = 0; k < 20; k++) begin
            tick();
            check_eq("mis_halt_valid", 32'(out_valid), 32'd0);
        end
        check_eq("mis_flag_sticky", 32'(fetch_misalign), 32'd1);
`else
        check_eq("mis_flag_off", 32'(fetch_misalign), 32'd0);
        tick();
        check_eq("mis_drop_valid", 32'(out_valid), 32'd1);
        check_eq("mis_drop_pc", out_pc, 32'h40);
        check_eq("mis_drop_instr", out_instr, 32'd16);
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        redirect_valid = 1'b0;
        check_eq("align_flag_clear", 32'(fetch_misalign), 32'd0);
        check_eq("align_bubble", 32'(out_valid), 32'd0);
        tick();
        check_eq("align_valid", 32'(out_valid), 32'd1);
        check_eq("align_pc", out_pc, 32'h80);
        check_eq("align_instr", out_instr, 32'd32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
